// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU: control-bundle field indices
// and the memory-access FSM state encoding.
package cpu_pkg;

    // WB control bundle field positions
    localparam int unsigned WB_MEMTOREG = 0;
    localparam int unsigned WB_RET      = 1;
    localparam int unsigned WB_REGWRITE = 2;
    localparam int unsigned WB_WADDR_HI = 6;
    localparam int unsigned WB_WADDR_LO = 3;

    // M control bundle field positions
    localparam int unsigned M_READ  = 0;
    localparam int unsigned M_WRITE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake sequencer: issues completion when the memory
// acknowledges and reports a stall for every cycle it is still pending.
module mem_access_fsm
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       need,
    input  logic       dmem_ready,
    output logic       complete,
    output logic       mem_stall,
    output mem_state_e state
);

    mem_state_e state_q, state_d;

    // State register; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, completion strobe and stall request
    always_comb begin
        state_d   = state_q;
        complete  = 1'b0;
        mem_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (need) begin
                    if (dmem_ready) begin
                        complete = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/mem_slice.sv
// Memory stage: EX/MEM pipeline register, data-memory request generation
// and the write-back / forwarding view of the instruction in this stage.
module mem_slice
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [15:0] PCret_in,
    input  logic [6:0]  WB_in,
    input  logic [1:0]  M_in,
    input  logic [15:0] ALU_in,
    input  logic [15:0] StoreData_in,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic        dmem_re,
    output logic        dmem_we,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [6:0]  WB_out,
    output logic [15:0] PCret_out,
    output logic [15:0] ALU_out,
    output logic [15:0] MemData_out,
    output logic        mem_stall,
    output logic [3:0]  fwd_addr,
    output logic        fwd_RegWrite
);

    logic [6:0]  wb_q, wb_d;
    logic [1:0]  m_q, m_d;
    logic [15:0] pcret_q, pcret_d;
    logic [15:0] alu_q, alu_d;
    logic [15:0] sd_q, sd_d;
    logic [15:0] rdata_q, rdata_d;
    logic        done_q, done_d;

    logic        need;
    logic        complete;
    logic        req;
    logic        load_en;
    mem_state_e  fsm_state;

    // done blocks re-issue of an access already completed while the stage is held
    assign need    = (m_q[M_READ] | m_q[M_WRITE]) & ~done_q;
    assign load_en = ~stall & ~mem_stall;
    // need is always high in WAIT; OR-ing the state keeps the request tied to the FSM
    assign req     = need | (fsm_state == WAIT);

    mem_access_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .need       (need),
        .dmem_ready (dmem_ready),
        .complete   (complete),
        .mem_stall  (mem_stall),
        .state      (fsm_state)
    );

    // Pipeline register load/hold, done flag and load-data capture
    always_comb begin
        wb_d    = wb_q;
        m_d     = m_q;
        pcret_d = pcret_q;
        alu_d   = alu_q;
        sd_d    = sd_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        if (complete) begin
            rdata_d = dmem_rdata;
            done_d  = 1'b1;
        end
        if (load_en) begin
            wb_d    = WB_in;
            m_d     = M_in;
            pcret_d = PCret_in;
            alu_d   = ALU_in;
            sd_d    = StoreData_in;
            done_d  = 1'b0;
        end
    end

    // Stage state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q    <= '0;
            m_q     <= '0;
            pcret_q <= '0;
            alu_q   <= '0;
            sd_q    <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            wb_q    <= wb_d;
            m_q     <= m_d;
            pcret_q <= pcret_d;
            alu_q   <= alu_d;
            sd_q    <= sd_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Memory request and write-back/forwarding outputs
    always_comb begin
        dmem_addr    = alu_q;
        dmem_wdata   = sd_q;
        // both M bits set decodes as a write only
        dmem_we      = req & m_q[M_WRITE];
        dmem_re      = req & m_q[M_READ] & ~m_q[M_WRITE];
        MemData_out  = complete ? dmem_rdata : rdata_q;
        WB_out       = mem_stall ? '0 : wb_q;
        PCret_out    = pcret_q;
        ALU_out      = alu_q;
        fwd_addr     = wb_q[WB_WADDR_HI:WB_WADDR_LO];
        fwd_RegWrite = wb_q[WB_REGWRITE] & ~mem_stall;
    end

endmodule

// File: tb/tb_mem_slice.sv
// Self-checking bench for mem_slice: expected write-back results are queued
// when an instruction is driven and compared when the stage releases it.
module tb_mem_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [15:0] PCret_in;
    logic [6:0]  WB_in;
    logic [1:0]  M_in;
    logic [15:0] ALU_in;
    logic [15:0] StoreData_in;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_re;
    logic        dmem_we;
    logic [15:0] dmem_rdata;
    logic        dmem_ready;
    logic [6:0]  WB_out;
    logic [15:0] PCret_out;
    logic [15:0] ALU_out;
    logic [15:0] MemData_out;
    logic        mem_stall;
    logic [3:0]  fwd_addr;
    logic        fwd_RegWrite;

    typedef struct {
        logic [6:0]  wb;
        logic [15:0] pc;
        logic [15:0] alu;
        logic [15:0] md;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          w0;
    logic [15:0] last_rdata = '0;

    mem_slice dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .PCret_in     (PCret_in),
        .WB_in        (WB_in),
        .M_in         (M_in),
        .ALU_in       (ALU_in),
        .StoreData_in (StoreData_in),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_re      (dmem_re),
        .dmem_we      (dmem_we),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .WB_out       (WB_out),
        .PCret_out    (PCret_out),
        .ALU_out      (ALU_out),
        .MemData_out  (MemData_out),
        .mem_stall    (mem_stall),
        .fwd_addr     (fwd_addr),
        .fwd_RegWrite (fwd_RegWrite)
    );

    always #5 clk = ~clk;

    // Memory-side count of accepted writes
    always @(posedge clk) begin
        if (rst && dmem_we && dmem_ready) wr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic randomize_inputs();
        WB_in        = 7'($urandom);
        M_in         = 2'($urandom);
        PCret_in     = 16'($urandom);
        ALU_in       = 16'($urandom);
        StoreData_in = 16'($urandom);
        dmem_rdata   = 16'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_re"},    32'(dmem_re),      32'h0);
        check_eq({tag, "_we"},    32'(dmem_we),      32'h0);
        check_eq({tag, "_stall"}, 32'(mem_stall),    32'h0);
        check_eq({tag, "_wb"},    32'(WB_out),       32'h0);
        check_eq({tag, "_pc"},    32'(PCret_out),    32'h0);
        check_eq({tag, "_alu"},   32'(ALU_out),      32'h0);
        check_eq({tag, "_md"},    32'(MemData_out),  32'h0);
        check_eq({tag, "_addr"},  32'(dmem_addr),    32'h0);
        check_eq({tag, "_wdata"}, 32'(dmem_wdata),   32'h0);
        check_eq({tag, "_fwda"},  32'(fwd_addr),     32'h0);
        check_eq({tag, "_fwdw"},  32'(fwd_RegWrite), 32'h0);
    endtask

    // Drive one instruction, serve its memory access after `waits` wait
    // states, then hold the stage with stall=1 for `hold` cycles.
    task automatic do_instr(input logic [6:0] wb, input logic [1:0] m,
                            input logic [15:0] pc, input logic [15:0] alu,
                            input logic [15:0] sd, input logic [15:0] rd,
                            input int waits, input int hold);
        exp_t e;
        exp_t g;
        logic is_mem;
        logic exp_stall;
        is_mem = (m != 2'b00);
        e.wb   = wb;
        e.pc   = pc;
        e.alu  = alu;
        e.md   = is_mem ? rd : last_rdata;
        sb_q.push_back(e);
        if (is_mem) last_rdata = rd;
        WB_in        = wb;
        M_in         = m;
        PCret_in     = pc;
        ALU_in       = alu;
        StoreData_in = sd;
        stall        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= waits; k++) begin
            exp_stall = is_mem && (k < waits);
            WB_in        = 7'($urandom);
            M_in         = 2'($urandom);
            PCret_in     = 16'($urandom);
            ALU_in       = 16'($urandom);
            StoreData_in = 16'($urandom);
            dmem_ready   = (k == waits);
            dmem_rdata   = (k == waits) ? rd : 16'($urandom);
            #1;
            check_eq("dmem_re", 32'(dmem_re), 32'(m == 2'b01));
            check_eq("dmem_we", 32'(dmem_we), 32'(m[1]));
            if (is_mem) begin
                check_eq("dmem_addr",  32'(dmem_addr),  32'(alu));
                check_eq("dmem_wdata", 32'(dmem_wdata), 32'(sd));
            end
            check_eq("mem_stall",    32'(mem_stall),    32'(exp_stall));
            check_eq("fwd_addr",     32'(fwd_addr),     32'(wb[6:3]));
            check_eq("fwd_regwrite", 32'(fwd_RegWrite), 32'(wb[2] & ~exp_stall));
            if (exp_stall) begin
                check_eq("wb_bubble", 32'(WB_out), 32'h0);
                @(posedge clk);
                @(negedge clk);
            end else begin
                check_eq("sb_size", 32'(sb_q.size()), 32'd1);
                if (sb_q.size() > 0) begin
                    g = sb_q.pop_front();
                    check_eq("wb_out",  32'(WB_out),      32'(g.wb));
                    check_eq("pcret",   32'(PCret_out),   32'(g.pc));
                    check_eq("alu_out", 32'(ALU_out),     32'(g.alu));
                    check_eq("memdata", 32'(MemData_out), 32'(g.md));
                end
            end
        end
        for (int j = 0; j < hold; j++) begin
            stall = 1'b1;
            @(posedge clk);
            @(negedge clk);
            dmem_ready = 1'($urandom);
            dmem_rdata = 16'($urandom);
            #1;
            check_eq("hold_re",    32'(dmem_re),     32'h0);
            check_eq("hold_we",    32'(dmem_we),     32'h0);
            check_eq("hold_stall", 32'(mem_stall),   32'h0);
            check_eq("hold_wb",    32'(WB_out),      32'(wb));
            check_eq("hold_md",    32'(MemData_out), 32'(e.md));
            check_eq("hold_alu",   32'(ALU_out),     32'(alu));
        end
    endtask

    initial begin
        rst        = 1'b0;
        stall      = 1'($urandom);
        dmem_ready = 1'($urandom);
        randomize_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            randomize_inputs();
            stall      = 1'($urandom);
            dmem_ready = 1'($urandom);
            #1;
            check_all_zero("reset");
        end
        dmem_ready = 1'b0;
        stall      = 1'b0;
        rst        = 1'b1;
        #1;

        // first clean instruction, then zero-wait load
        do_instr(7'h1C, 2'b00, 16'h0100, 16'h0007, 16'h0000, 16'h0000, 0, 0);
        do_instr(7'h2D, 2'b01, 16'h0102, 16'h0040, 16'h0000, 16'hBEEF, 0, 0);

        // two-wait store, held afterwards: exactly one write
        w0 = wr_cnt;
        do_instr(7'h00, 2'b10, 16'h0104, 16'h0010, 16'h1234, 16'h5A5A, 2, 2);
        do_instr(7'h1C, 2'b00, 16'h0106, 16'h0003, 16'h0000, 16'h0000, 0, 0);
        check_eq("store_count", 32'(wr_cnt - w0), 32'd1);

        // load completed then held for 3 cycles
        do_instr(7'h2D, 2'b01, 16'h0108, 16'h0044, 16'h0000, 16'hCAFE, 0, 3);
        // load to r5 waiting 3 cycles; forwarding suppressed until completion
        do_instr(7'h2D, 2'b01, 16'h010A, 16'h0048, 16'h0000, 16'h1357, 3, 0);
        // illegal M=11 behaves as a write
        do_instr(7'h00, 2'b11, 16'h010C, 16'h0020, 16'hA5A5, 16'h0F0F, 1, 1);

        for (int i = 0; i < 8; i++) begin
            logic [1:0] m;
            m = 2'($urandom);
            do_instr(7'($urandom), m, 16'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom), (m != 2'b00) ? int'($urandom_range(0, 3)) : 0,
                     int'($urandom_range(0, 2)));
        end

        // reset in the middle of a pending load
        WB_in  = 7'h2D;
        M_in   = 2'b01;
        ALU_in = 16'h0080;
        stall  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        check_eq("pend_stall", 32'(mem_stall), 32'h1);
        check_eq("pend_re",    32'(dmem_re),   32'h1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("wait_stall", 32'(mem_stall), 32'h1);
        rst = 1'b0;
        #1;
        check_all_zero("rst_wait");
        w0 = wr_cnt;
        randomize_inputs();
        dmem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("rst_hold");
        dmem_ready = 1'b0;
        stall      = 1'b0;
        rst        = 1'b1;
        last_rdata = '0;
        #1;
        check_eq("post_rst_wb",    32'(WB_out),    32'h0);
        check_eq("post_rst_stall", 32'(mem_stall), 32'h0);
        do_instr(7'h1C, 2'b00, 16'h0200, 16'h0009, 16'h0000, 16'h0000, 0, 1);
        check_eq("rst_no_write", 32'(wr_cnt - w0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
